core_driver: RTL
================

CORE_DRIVER -- requirements
Module: core_driver

Interface
REQ-001 Parameter WAIT_MAX, default 1024: maximum cycles spent in any core-wait state before an error is flagged.
REQ-002 clk  input  1  single clock; all state updates occur on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  one-cycle pulse that begins a message.
REQ-005 mode  input  1  sampled on start; 0 = encrypt, 1 = decrypt.
REQ-006 s_valid, s_ready, s_last  in/out/in  1 each  upstream block handshake; a beat transfers when s_valid and s_ready are both 1.
REQ-007 s_type  input  2  block type: 00 key, 01 nonce, 10 associated data, 11 message data.
REQ-008 s_data  input  128  upstream block.
REQ-009 m_valid, m_ready  out/in  1 each  result handshake.
REQ-010 m_data  output  128  result word.
REQ-011 core_in  output  128  block bus to the cipher core.
REQ-012 core_ready_i, core_k_n, core_a_p, core_e_d, core_ready_k, core_done, core_term  output  1 each  core control strobes.
REQ-013 core_ready, core_ready_o  input  1 each  core status inputs.
REQ-014 core_out  input  128  core result.
REQ-015 busy, err  output  1 each  message in progress; sticky protocol or timeout error.

Function
REQ-016 States: IDLE, KEY, NONCE, INIT_WAIT, AD, AD_WAIT, DATA, DONE, OUT, FIN_WAIT, TERM, ERR.
REQ-017 All core_* outputs, m_valid, busy and err shall be registered.
REQ-018 core_ready rising edge shall be detected against a registered copy of core_ready; a level that is already high does not count.
REQ-019 IDLE: start is ignored while m_valid=1; otherwise start latches mode into core_e_d, sets busy=1, and goes to KEY.
REQ-020 s_ready=1 only in KEY, NONCE, AD and DATA.
REQ-021 KEY: a type-00 beat drives core_in=s_data, core_k_n=0 and core_ready_i=1 for exactly the next cycle, then goes to NONCE.
REQ-022 NONCE: a type-01 beat drives core_in=s_data, core_k_n=1 and core_ready_i=1 for one cycle, sets core_ready_k=1, then goes to INIT_WAIT.
REQ-023 core_ready_k shall stay 1 until the cycle after TERM.
REQ-024 INIT_WAIT: a core_ready rising edge goes to AD.
REQ-025 AD: a type-10 beat issues core_ready_i=1 with core_a_p=0 for one cycle, then goes to AD_WAIT.
REQ-026 AD_WAIT: a core_ready rising edge goes back to AD.
REQ-027 AD: a type-11 beat, including with zero AD blocks, is handled as the first DATA beat.
REQ-028 DATA: each type-11 beat issues core_ready_i=1 with core_a_p=1 for one cycle; back-to-back beats are allowed.
REQ-029 DATA: the beat with s_last=1 goes to DONE.
REQ-030 DONE: core_done=1 for exactly one cycle, in the cycle after the last core_ready_i, then OUT.
REQ-031 OUT: a cycle with core_ready_o=1 loads m_data=core_out and sets m_valid=1, then goes to FIN_WAIT.
REQ-032 FIN_WAIT: a core_ready rising edge goes to TERM.
REQ-033 TERM: core_term=1 for one cycle, then busy=0 and IDLE.
REQ-034 m_valid shall hold with m_data stable until an m_ready cycle, and is independent of FSM progress.
REQ-035 A beat whose s_type does not match the state, or s_last=1 on a non-data beat, goes to ERR.
REQ-036 A timeout counter is cleared on entry to INIT_WAIT, AD_WAIT, OUT and FIN_WAIT; reaching WAIT_MAX in any of them goes to ERR.
REQ-037 ERR: sets err=1, busy=0, all core strobes 0 and s_ready=0; a later start clears err and restarts the flow at KEY.
REQ-038 core_ready_i=0 in every cycle not listed above; core_in holds its last value.

Reset
REQ-039 When rst=0, asynchronously: state IDLE; all core_* outputs 0; core_in 0; m_data 0; m_valid, busy, err 0; edge register 0; timeout counter 0.
REQ-040 Reset mid-message shall abort without issuing core_term.

Verification
REQ-041 Encrypt: key, nonce, 1 AD, 1 data (s_last=1), core model asserting ready 3 cycles after each request -> strobe order key, nonce, ready_k, AD(a_p=0), data(a_p=1), done, term; m_data=core_out at ready_o.
REQ-042 Decrypt with the same key, nonce and AD, data = the previous m_data -> core_e_d=1 throughout, and m_data = 6d25cf734c49a1dd273e4d8f5f5bdb01 from the reference core.
REQ-043 Zero AD, three back-to-back data beats -> core_ready_i high 3 consecutive cycles with a_p=1, then core_done exactly 1 cycle later.
REQ-044 Nonce sent before key -> err=1, s_ready=0, no core_ready_k; a following start recovers and completes normally.
REQ-045 Core never raises ready in INIT_WAIT, WAIT_MAX=16 -> err=1 after 16 cycles.
REQ-046 rst pulsed low during AD_WAIT -> all outputs 0 immediately, no core_term issued; m_ready held low at OUT -> m_valid held, later start ignored until m_ready.

Source files
------------

// File: rtl/core_driver.sv
// Sequencer between a block-stream source and an AEAD cipher core: walks key, nonce,
// associated data and message blocks into the core, then returns one result word.
module core_driver #(
  parameter int unsigned WAIT_MAX = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         mode,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic         s_last,
  input  logic [1:0]   s_type,
  input  logic [127:0] s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [127:0] m_data,
  output logic [127:0] core_in,
  output logic         core_ready_i,
  output logic         core_k_n,
  output logic         core_a_p,
  output logic         core_e_d,
  output logic         core_ready_k,
  output logic         core_done,
  output logic         core_term,
  input  logic         core_ready,
  input  logic         core_ready_o,
  input  logic [127:0] core_out,
  output logic         busy,
  output logic         err
);

  localparam int unsigned TW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

  typedef enum logic [3:0] {
    StIdle, StKey, StNonce, StInitWait, StAd, StAdWait,
    StData, StDone, StOut, StFinWait, StTerm, StErr
  } state_e;

  state_e        state_q;
  logic          core_ready_q;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          rise, s_xfer, beat_bad, wait_st, progress, timeout, to_err, start_ok;

  always_comb begin
    s_ready  = 1'b0;
    beat_bad = 1'b0;
    wait_st  = 1'b0;
    progress = 1'b0;
    rise     = core_ready & ~core_ready_q;
    case (state_q)
      StKey: begin
        s_ready  = 1'b1;
        beat_bad = (s_type != 2'b00) || s_last;
      end
      StNonce: begin
        s_ready  = 1'b1;
        beat_bad = (s_type != 2'b01) || s_last;
      end
      StAd: begin
        s_ready  = 1'b1;
        // A message beat here means there is no (more) associated data.
        beat_bad = !((s_type == 2'b11) || (s_type == 2'b10 && !s_last));
      end
      StData: begin
        s_ready  = 1'b1;
        beat_bad = (s_type != 2'b11);
      end
      StInitWait, StAdWait, StFinWait: begin
        wait_st  = 1'b1;
        progress = rise;
      end
      StOut: begin
        wait_st  = 1'b1;
        progress = core_ready_o;
      end
      default: ;
    endcase
    s_xfer   = s_valid & s_ready;
    timeout  = wait_st & ~progress & (tmr_q == TW'(WAIT_MAX - 1));
    to_err   = (s_xfer & beat_bad) | timeout;
    tmr_d    = (wait_st & ~progress) ? tmr_q + 1'b1 : '0;
    start_ok = start & ~m_valid;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      core_ready_q <= 1'b0;
      tmr_q        <= '0;
      core_in      <= '0;
      core_ready_i <= 1'b0;
      core_k_n     <= 1'b0;
      core_a_p     <= 1'b0;
      core_e_d     <= 1'b0;
      core_ready_k <= 1'b0;
      core_done    <= 1'b0;
      core_term    <= 1'b0;
      m_data       <= '0;
      m_valid      <= 1'b0;
      busy         <= 1'b0;
      err          <= 1'b0;
    end else begin
      core_ready_q <= core_ready;
      tmr_q        <= tmr_d;
      core_ready_i <= 1'b0;
      core_done    <= 1'b0;
      core_term    <= 1'b0;
      if (m_valid && m_ready) m_valid <= 1'b0;

      if (to_err) begin
        state_q      <= StErr;
        err          <= 1'b1;
        busy         <= 1'b0;
        core_k_n     <= 1'b0;
        core_a_p     <= 1'b0;
        core_e_d     <= 1'b0;
        core_ready_k <= 1'b0;
      end else begin
        case (state_q)
          StIdle, StErr: begin
            core_ready_k <= 1'b0;
            busy         <= 1'b0;
            if (start_ok) begin
              core_e_d <= mode;
              busy     <= 1'b1;
              err      <= 1'b0;
              state_q  <= StKey;
            end
          end
          StKey: if (s_xfer) begin
            core_in      <= s_data;
            core_k_n     <= 1'b0;
            core_ready_i <= 1'b1;
            state_q      <= StNonce;
          end
          StNonce: if (s_xfer) begin
            core_in      <= s_data;
            core_k_n     <= 1'b1;
            core_ready_i <= 1'b1;
            core_ready_k <= 1'b1;
            state_q      <= StInitWait;
          end
          StInitWait: if (rise) state_q <= StAd;
          StAd: if (s_xfer) begin
            core_in      <= s_data;
            core_ready_i <= 1'b1;
            if (s_type == 2'b10) begin
              core_a_p <= 1'b0;
              state_q  <= StAdWait;
            end else begin
              core_a_p <= 1'b1;
              state_q  <= s_last ? StDone : StData;
            end
          end
          StAdWait: if (rise) state_q <= StAd;
          StData: if (s_xfer) begin
            core_in      <= s_data;
            core_a_p     <= 1'b1;
            core_ready_i <= 1'b1;
            if (s_last) state_q <= StDone;
          end
          StDone: begin
            core_done <= 1'b1;
            state_q   <= StOut;
          end
          StOut: if (core_ready_o) begin
            m_data  <= core_out;
            m_valid <= 1'b1;
            state_q <= StFinWait;
          end
          StFinWait: if (rise) state_q <= StTerm;
          StTerm: begin
            // ready_k and busy drop on the following idle cycle, after the term strobe.
            core_term <= 1'b1;
            state_q   <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule
